// File: rtl/aes_pkg.sv
// aes_pkg
// Shared AES-128 definitions for the key schedule and the SubBytes stage.
// Contents:
//   AES_NR       number of AES-128 rounds
//   aes_block_t  128-bit state / key block, byte 0 at [127:120]
//   aes_word_t   32-bit key-schedule word
//   AES_RCON     round constants rcon[1..10] (first byte of the Rcon word)
//   AES_SBOX     forward S-box, entry for byte 8'h00 in the top 8 bits
//   rot_word()   cyclic left rotation of a word by one byte
//   sbox_byte()  single forward S-box lookup
package aes_pkg;

    localparam int AES_NR = 10;

    typedef logic [127:0] aes_block_t;
    typedef logic [31:0]  aes_word_t;

    localparam logic [7:0] AES_RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // One row of the S-box per line, rows 0x0_ .. 0xf_ from top to bottom.
    localparam logic [2047:0] AES_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic aes_word_t rot_word(input aes_word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    // Entry b sits at bit offset (255-b)*8, and 255-b is simply ~b for a byte.
    function automatic logic [7:0] sbox_byte(input logic [7:0] b);
        return AES_SBOX[{~b, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/aes_sbox4.sv
// aes_sbox4
// Combinational SubWord: four parallel forward S-box byte lookups.
// Also used by the SubBytes stage, so it carries no key-schedule specifics.
// Ports:
//   word  in   32  input word
//   sub   out  32  S-box applied to each byte of word
module aes_sbox4
    import aes_pkg::*;
(
    input  aes_word_t word,
    output aes_word_t sub
);

    // Each byte lane is looked up independently; lanes never interact.
    always_comb begin
        sub = '0;
        for (int i = 0; i < 4; i++) begin
            sub[i*8 +: 8] = sbox_byte(word[i*8 +: 8]);
        end
    end

endmodule

// File: rtl/aes_key_expand_seq.sv
// aes_key_expand_seq
// Iterative AES-128 key schedule feeding the round-key XOR stage. One working
// key register holds the current round key; a single SubWord is reused for
// every round. Round keys RK0..RK10 are offered one at a time on valid/ready.
// Ports:
//   clk        in   1    rising-edge clock
//   rst        in   1    synchronous active-high reset
//   start      in   1    request; key_in is sampled when start=1 in IDLE
//   key_in     in   128  cipher key, w0=[127:96] .. w3=[31:0]
//   key_ready  in   1    consumer accepts the current round_key
//   key_valid  out  1    round_key / round_idx are valid
//   round_key  out  128  current round key RKn
//   round_idx  out  4    n of the current key, 0..10
//   busy       out  1    high in every state except IDLE
//   done       out  1    one-cycle pulse after RK10 is accepted
module aes_key_expand_seq
    import aes_pkg::*;
#(
    parameter int NR    = AES_NR,
    parameter int KEY_W = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_ready,
    output logic             key_valid,
    output logic [KEY_W-1:0] round_key,
    output logic [3:0]       round_idx,
    output logic             busy,
    output logic             done
);

    // Only the AES-128 schedule is implemented; anything else must not build.
    generate
        if (NR != AES_NR || KEY_W != 128) begin : g_bad_param
            $error("aes_key_expand_seq supports only NR=10 and KEY_W=128");
        end
    endgenerate

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_VALID = 2'd1;
    localparam logic [1:0] S_CALC  = 2'd2;

    localparam logic [3:0] LAST_IDX = 4'(NR);

    logic [1:0] state;
    aes_word_t  w0, w1, w2, w3;
    aes_word_t  sub_w;
    aes_word_t  t;
    aes_word_t  n0, n1, n2, n3;
    logic [3:0] rcon_sel;

    assign w0 = round_key[127:96];
    assign w1 = round_key[95:64];
    assign w2 = round_key[63:32];
    assign w3 = round_key[31:0];

    aes_sbox4 u_sbox4 (
        .word (rot_word(w3)),
        .sub  (sub_w)
    );

    // Next round key from the current one. The rcon index is only meaningful
    // in CALC (round_idx 0..NR-1); it is clamped so it never leaves 1..10.
    always_comb begin
        rcon_sel = (round_idx < LAST_IDX) ? round_idx + 4'd1 : 4'd1;
        t  = sub_w ^ {AES_RCON[rcon_sel], 24'h000000};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
    end

    assign key_valid = (state == S_VALID);
    assign busy      = (state != S_IDLE);

    // Sequencer: IDLE loads the cipher key, VALID waits for the consumer,
    // CALC advances the working key by one round. start is only looked at in
    // IDLE, so a start during a schedule (including the final handshake
    // cycle) is dropped. done is a registered one-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            round_key <= '0;
            round_idx <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        round_key <= key_in;
                        round_idx <= 4'd0;
                        state     <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (key_ready) begin
                        if (round_idx == LAST_IDX) begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    round_key <= {n0, n1, n2, n3};
                    round_idx <= round_idx + 4'd1;
                    state     <= S_VALID;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// tb_aes_key_expand_seq
// Self-checking bench for aes_key_expand_seq. The reference schedule is the
// textbook word-recursive expansion w[i] = w[i-4] ^ f(w[i-1]), with the S-box
// derived from GF(2^8) inversion plus the affine map, and rcon from doubling.
module tb_aes_key_expand_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         key_ready;
    logic         key_valid;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sboxTable [0:255];
    logic [7:0]   rconTable [1:10];
    logic [127:0] refKeys   [0:10];
    logic [127:0] seenKeys  [0:10];

    always #5 clk = ~clk;

    aes_key_expand_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .key_ready (key_ready),
        .key_valid (key_valid),
        .round_key (round_key),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done)
    );

    // Hard stop in case the handshake logic wedges somewhere unbounded.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    // S-box = affine transform of the multiplicative inverse (0 maps to 0).
    task automatic buildTables();
        logic [7:0] inv;
        logic [7:0] r;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sboxTable[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                         ^ rotl8(inv, 4) ^ 8'h63;
        end
        r = 8'h01;
        for (int i = 1; i <= 10; i++) begin
            rconTable[i] = r;
            r = xtime(r);
        end
    endtask

    // Classic 44-word expansion; round key n is words 4n..4n+3.
    task automatic computeRef(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] temp;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = {temp[23:0], temp[31:24]};
                temp = {sboxTable[temp[31:24]], sboxTable[temp[23:16]],
                        sboxTable[temp[15:8]],  sboxTable[temp[7:0]]};
                temp = temp ^ {rconTable[i/4], 24'h000000};
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int n = 0; n <= 10; n++) begin
            refKeys[n] = {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Presents a key with a one-cycle start; the key is scrambled afterwards
    // because it must no longer matter.
    task automatic applyStimulus(input logic [127:0] key);
        start  = 1'b1;
        key_in = key;
        stepCycle();
        start  = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Runs one full schedule. stallIdx/stallLen force a ready-low window,
    // injectIdx raises start with a foreign key at that round's handshake,
    // randomStalls adds random back-pressure, finalStart raises start on the
    // final handshake.
    task automatic runSchedule(input logic [127:0] key, input int stallIdx,
                               input int stallLen, input int injectIdx,
                               input bit randomStalls, input bit finalStart);
        int edges;
        int budget;
        int hold;
        computeRef(key);
        applyStimulus(key);
        edges = 1;
        for (int n = 0; n <= 10; n++) begin
            budget = 0;
            while (!key_valid && budget < 8) begin
                key_ready = 1'($urandom_range(0, 1));
                stepCycle();
                edges++;
                budget++;
            end
            if (!key_valid) begin
                checkOutput("valid_timeout", 128'(key_valid), 128'(1));
                return;
            end
            checkOutput("hs_to_valid_gap", 128'(budget), 128'((n == 0) ? 0 : 1));
            checkOutput("round_idx", 128'(round_idx), 128'(n));
            checkOutput("round_key", round_key, refKeys[n]);
            seenKeys[n] = round_key;

            hold = (n == stallIdx) ? stallLen : (randomStalls ? int'($urandom_range(0, 3)) : 0);
            for (int h = 0; h < hold; h++) begin
                key_ready = 1'b0;
                stepCycle();
                edges++;
                checkOutput("stall_valid", 128'(key_valid), 128'(1));
                checkOutput("stall_idx", 128'(round_idx), 128'(n));
                checkOutput("stall_key", round_key, refKeys[n]);
            end

            key_ready = 1'b1;
            if (n == injectIdx) begin
                start  = 1'b1;
                key_in = ~key;
            end
            if (n == 10 && finalStart) start = 1'b1;
            stepCycle();
            edges++;
            start  = 1'b0;
            key_in = {$urandom, $urandom, $urandom, $urandom};

            checkOutput("valid_after_hs", 128'(key_valid), 128'(0));
            if (n == 10) begin
                checkOutput("done_pulse", 128'(done), 128'(1));
                checkOutput("busy_at_done", 128'(busy), 128'(0));
                if (stallLen == 0 && !randomStalls) begin
                    checkOutput("start_to_done", 128'(edges), 128'(22));
                end
                key_ready = 1'($urandom_range(0, 1));
                stepCycle();
                checkOutput("done_one_cycle", 128'(done), 128'(0));
                checkOutput("idle_busy", 128'(busy), 128'(0));
                checkOutput("idle_valid", 128'(key_valid), 128'(0));
            end else begin
                checkOutput("done_early", 128'(done), 128'(0));
                checkOutput("busy_mid", 128'(busy), 128'(1));
            end
        end
    endtask

    // Test sequence: reset, FIPS vector, zero key, back-pressure, ignored
    // start, mid-schedule reset, start on the final handshake, random keys.
    initial begin
        int budget;
        rst       = 1'b1;
        start     = 1'b0;
        key_ready = 1'b0;
        key_in    = '0;
        buildTables();
        stepCycle();
        stepCycle();
        checkOutput("reset_valid", 128'(key_valid), 128'(0));
        checkOutput("reset_busy", 128'(busy), 128'(0));
        checkOutput("reset_done", 128'(done), 128'(0));
        checkOutput("reset_key", round_key, 128'h0);
        checkOutput("reset_idx", 128'(round_idx), 128'(0));
        rst = 1'b0;
        key_ready = 1'b1;
        stepCycle();
        checkOutput("idle_ready_no_effect", 128'(key_valid), 128'(0));

        $display("[TB] FIPS-197 key, ready held high");
        runSchedule(128'h2b7e151628aed2a6abf7158809cf4f3c, -1, 0, -1, 1'b0, 1'b0);
        checkOutput("fips_rk0", seenKeys[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        checkOutput("fips_rk1", seenKeys[1], 128'ha0fafe1788542cb123a339392a6c7605);
        checkOutput("fips_rk10", seenKeys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        $display("[TB] all-zero key");
        runSchedule(128'h0, -1, 0, -1, 1'b0, 1'b0);
        checkOutput("zero_rk1", seenKeys[1], 128'h62636363626363636263636362636363);
        checkOutput("zero_rk10", seenKeys[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        $display("[TB] back-pressure at round 3");
        runSchedule({$urandom, $urandom, $urandom, $urandom}, 3, 5, -1, 1'b0, 1'b0);

        $display("[TB] start while busy at round 5");
        runSchedule({$urandom, $urandom, $urandom, $urandom}, -1, 0, 5, 1'b0, 1'b0);

        $display("[TB] reset at round 7");
        applyStimulus({$urandom, $urandom, $urandom, $urandom});
        key_ready = 1'b1;
        budget = 0;
        while (!(key_valid && round_idx == 4'd7) && budget < 40) begin
            stepCycle();
            budget++;
        end
        checkOutput("reach_round7", 128'(round_idx), 128'(7));
        key_ready = 1'b0;
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        checkOutput("mid_rst_busy", 128'(busy), 128'(0));
        checkOutput("mid_rst_valid", 128'(key_valid), 128'(0));
        checkOutput("mid_rst_done", 128'(done), 128'(0));
        checkOutput("mid_rst_idx", 128'(round_idx), 128'(0));
        stepCycle();
        checkOutput("post_rst_valid", 128'(key_valid), 128'(0));
        runSchedule({$urandom, $urandom, $urandom, $urandom}, -1, 0, -1, 1'b0, 1'b0);

        $display("[TB] start on the final handshake");
        runSchedule({$urandom, $urandom, $urandom, $urandom}, -1, 0, -1, 1'b0, 1'b1);

        $display("[TB] random keys with random back-pressure");
        for (int r = 0; r < 4; r++) begin
            runSchedule({$urandom, $urandom, $urandom, $urandom}, -1, 0, -1, 1'b1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
